hub75_scan_ctrl: RTL and testbench
==================================

# hub75_scan_ctrl

Row-scan and shift controller for the 1bpp HUB75 LED panel path. It walks the framebuffer two rows at a time, one row in each panel half, and issues read addresses for the top and bottom pixel. The pixel words returned by the framebuffer feed the RGB bit-select stage, which drives r0/g0/b0/r1/g1/b1. This block generates every panel control line: shift clock, latch, output enable and row address. It sits directly upstream of the RGB bit-select stage and downstream of the framebuffer RAM.

## Interface
- COLS, 64: panel width in pixels; must be ≥ 2.
- ROWS, 32: panel height in pixels. HALF = ROWS/2 is the number of scan rows.
- CLK_DIV, 2: system cycles per shift-clock phase (low, high); must be ≥ 2.
- OE_CYCLES, 256: system cycles that the output enable is asserted per row; must be ≥ 1.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; sampled only at row boundaries.
- fb_rd_en  out  1  framebuffer read strobe.
- fb_addr_top  out  $clog2(ROWS*COLS)  read address for the top half: row*COLS + col.
- fb_addr_bot  out  $clog2(ROWS*COLS)  read address for the bottom half: (row+HALF)*COLS + col.
- panel_clk  out  1  HUB75 shift clock; the panel samples on the rising edge.
- panel_lat  out  1  HUB75 latch, active high.
- panel_oe_n  out  1  HUB75 output enable, active low.
- row_addr  out  $clog2(HALF)  HUB75 row select (A/B/C/D/E).
- frame_done  out  1  one-cycle pulse at the end of each full frame.

## Operation

**Reset values (all registered):**
- panel_clk=0, panel_lat=0, panel_oe_n=1.
- row_addr=0, fb_addr_top=0, fb_addr_bot=0.
- fb_rd_en=0, frame_done=0.
- State IDLE; internal row=0, col=0.

**Framebuffer:** synchronous RAM with 1-cycle read latency. The bit-select stage is combinational, so RGB data is valid one cycle after the address changes.

**FSM states:**
- IDLE:
  - panel_oe_n=1, panel_clk=0.
  - When en=1, go to SHIFT with col=0.
- SHIFT:
  - Per column, the address is presented with fb_rd_en=1 on the first cycle of the low phase.
  - panel_clk=0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
  - col advances at the end of the high phase.
  - After col=COLS-1 completes, go to BLANK. panel_clk returns to 0.
  - panel_oe_n=1 throughout SHIFT.
- BLANK (1 cycle):
  - panel_oe_n=1.
  - row_addr takes the value of the row just shifted.
- LATCH (1 cycle):
  - panel_lat=1.
  - panel_oe_n=1.
- DISPLAY:
  - panel_oe_n=0 for exactly OE_CYCLES cycles.
  - On the last cycle, row advances. It wraps HALF-1→0, and frame_done=1 on that wrap cycle only.
  - Next state: SHIFT if en=1, else IDLE with panel_oe_n=1 and row held.

**Arithmetic:**
- Addresses are computed from row/col at full address width. No truncation, because ROWS*COLS ≤ 2^width.
- The col counter uses $clog2(COLS) bits. The row counter uses $clog2(HALF) bits.

**Boundary conditions:**
- Row wrap: row=HALF-1 → 0 together with the frame_done pulse. No extra cycles are inserted.
- en deassert mid-row: the current SHIFT/BLANK/LATCH/DISPLAY sequence completes, then the FSM goes to IDLE.
- en reassert while in IDLE: resumes at the held row, with col=0.
- rst_n asserted mid-operation: all outputs go to their reset values immediately (asynchronously). panel_oe_n=1 immediately, so there is no lit-row glitch.
- panel_lat and panel_oe_n=0 are never asserted in the same cycle.
- panel_clk never toggles outside SHIFT.

## Timing
- Data setup: RGB is valid CLK_DIV-1 cycles (≥1) before each panel_clk rising edge, and is held for CLK_DIV cycles after it.
- Cycles per row: COLS*2*CLK_DIV + 2 + OE_CYCLES.
- Frame period: HALF × the row period.
- Start-up: with en high out of reset, the first fb_rd_en occurs on the first cycle after IDLE samples en=1.
- Latency from en=1 in IDLE to the first panel_clk rise: 1 + CLK_DIV cycles.

## Structure
- Package hub75_pkg holds:
  - the state enum (IDLE, SHIFT, BLANK, LATCH, DISPLAY);
  - derived width functions for address, row and column;
  - the default COLS/ROWS constants shared with the framebuffer and the bit-select stage.
- One sub-module, hub75_bitclk_gen:
  - phase counter producing panel_clk, a low-phase-start strobe and a column-done strobe;
  - parameterised by CLK_DIV;
  - enabled only in SHIFT.

## Test plan
1. Reset values:
   - Stimulus: hold rst_n=0 and toggle en.
   - Required: panel_oe_n=1, panel_lat=0, panel_clk=0, row_addr=0 and frame_done=0 throughout.
2. Single-row timing:
   - Stimulus: COLS=4, ROWS=4, CLK_DIV=2, OE_CYCLES=5; raise en.
   - Required: 4 panel_clk pulses (2 low + 2 high each), then BLANK, one lat cycle, 5 cycles of oe_n=0; row period 23 cycles.
3. Addressing:
   - Stimulus: COLS=4, ROWS=4; run one full frame.
   - Required: row 1 col 2 gives fb_addr_top=6 and fb_addr_bot=14; each address is held for 4 cycles.
   - Required: the RGB outputs from a model RAM match the bits at every panel_clk rise.
4. Frame wrap:
   - Stimulus: run two full frames.
   - Required: frame_done pulses exactly once per 46 cycles, on the DISPLAY cycle where row goes 1→0.
5. Enable drop:
   - Stimulus: deassert en during SHIFT of row 1.
   - Required: row 1 completes its latch and display, the FSM enters IDLE with oe_n=1 and row_addr=1, and on reassert resumes at row 1, col 0.
6. Reset mid-operation:
   - Stimulus: assert rst_n during DISPLAY.
   - Required: panel_oe_n=1 in the same cycle (asynchronously) and all outputs at reset values; after release, the first address issued is 0.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared types and sizing helpers for the HUB75 scan path (scan controller,
// framebuffer, bit-select stage).
package hub75_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    localparam int unsigned DEF_COLS = 64;
    localparam int unsigned DEF_ROWS = 32;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 2) w = unsigned'($clog2(n));
        return w;
    endfunction

    function automatic int unsigned addr_w(input int unsigned rows, input int unsigned cols);
        return cnt_w(rows * cols);
    endfunction

    function automatic int unsigned row_w(input int unsigned rows);
        return cnt_w(rows / 2);
    endfunction

    function automatic int unsigned col_w(input int unsigned cols);
        return cnt_w(cols);
    endfunction

endpackage

// File: rtl/hub75_bitclk_gen.sv
// Shift-clock phase generator: CLK_DIV cycles low then CLK_DIV cycles high per
// column, running only while the scan controller is in SHIFT.
module hub75_bitclk_gen
    import hub75_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic shift,
    input  logic shift_next,
    output logic panel_clk,
    output logic low_start_c,
    output logic col_done_c
);

    localparam int unsigned PER = 2 * CLK_DIV;
    localparam int unsigned PW  = cnt_w(PER);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_next;

    // Phase restarts at zero whenever a shift burst begins.
    always_comb begin
        phase_next = '0;
        if (shift && shift_next) begin
            phase_next = (phase == PW'(PER - 1)) ? '0 : phase + PW'(1);
        end
    end

    assign low_start_c = shift_next && (phase_next == '0);
    assign col_done_c  = shift && (phase == PW'(PER - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= '0;
            panel_clk <= 1'b0;
        end else begin
            phase     <= phase_next;
            panel_clk <= shift_next && (phase_next >= PW'(CLK_DIV));
        end
    end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 row-scan controller: shifts one row pair, blanks, latches, then lights
// it for OE_CYCLES cycles. All panel and framebuffer outputs are registered.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int unsigned COLS      = DEF_COLS,
    parameter int unsigned ROWS      = DEF_ROWS,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned OE_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    output logic                          fb_rd_en,
    output logic [addr_w(ROWS, COLS)-1:0] fb_addr_top,
    output logic [addr_w(ROWS, COLS)-1:0] fb_addr_bot,
    output logic                          panel_clk,
    output logic                          panel_lat,
    output logic                          panel_oe_n,
    output logic [row_w(ROWS)-1:0]        row_addr,
    output logic                          frame_done
);

    localparam int unsigned HALF = ROWS / 2;
    localparam int unsigned AW   = addr_w(ROWS, COLS);
    localparam int unsigned RW   = row_w(ROWS);
    localparam int unsigned CW   = col_w(COLS);
    localparam int unsigned OW   = cnt_w(OE_CYCLES);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] col;
    logic [CW-1:0] col_next;
    logic [RW-1:0] row;
    logic [RW-1:0] row_next;
    logic [OW-1:0] oe_cnt;
    logic [OW-1:0] oe_cnt_next;
    logic          run;
    logic          run_next;
    logic          frame_done_d;

    logic          shift_c;
    logic          shift_next_c;
    logic          low_start_c;
    logic          col_done_c;

    logic [AW-1:0] addr_top_d;
    logic [AW-1:0] addr_bot_d;
    logic [RW-1:0] row_addr_d;

    assign shift_c      = (state == SHIFT);
    assign shift_next_c = (state_next == SHIFT);

    hub75_bitclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bitclk (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift       (shift_c),
        .shift_next  (shift_next_c),
        .panel_clk   (panel_clk),
        .low_start_c (low_start_c),
        .col_done_c  (col_done_c)
    );

    // Next-state and counter logic.
    always_comb begin
        state_next   = state;
        col_next     = col;
        row_next     = row;
        oe_cnt_next  = oe_cnt;
        run_next     = run;
        frame_done_d = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    state_next = SHIFT;
                    col_next   = '0;
                end
            end
            SHIFT: begin
                if (col_done_c) begin
                    if (col == CW'(COLS - 1)) begin
                        state_next = BLANK;
                        col_next   = '0;
                    end else begin
                        col_next = col + CW'(1);
                    end
                end
            end
            BLANK:   state_next = LATCH;
            LATCH: begin
                state_next  = DISPLAY;
                oe_cnt_next = '0;
            end
            DISPLAY: begin
                if (oe_cnt == OW'(OE_CYCLES - 1)) begin
                    state_next = run ? SHIFT : IDLE;
                end else begin
                    oe_cnt_next = oe_cnt + OW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // Row boundary: en is taken as the final DISPLAY cycle is entered, so the
        // row advance and frame_done are visible during that last lit cycle.
        if ((state_next == DISPLAY) && (oe_cnt_next == OW'(OE_CYCLES - 1))) begin
            run_next = en;
            if (en) begin
                row_next     = (row == RW'(HALF - 1)) ? '0 : row + RW'(1);
                frame_done_d = (row == RW'(HALF - 1));
            end
        end
    end

    // Address and row-select lookahead for the registered outputs.
    always_comb begin
        addr_top_d = fb_addr_top;
        addr_bot_d = fb_addr_bot;
        row_addr_d = row_addr;
        if (low_start_c) begin
            addr_top_d = AW'(row) * AW'(COLS) + AW'(col_next);
            addr_bot_d = (AW'(row) + AW'(HALF)) * AW'(COLS) + AW'(col_next);
        end
        if (state_next == BLANK) begin
            row_addr_d = row;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            oe_cnt      <= '0;
            run         <= 1'b0;
            fb_rd_en    <= 1'b0;
            fb_addr_top <= '0;
            fb_addr_bot <= '0;
            panel_lat   <= 1'b0;
            panel_oe_n  <= 1'b1;
            row_addr    <= '0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_next;
            col         <= col_next;
            row         <= row_next;
            oe_cnt      <= oe_cnt_next;
            run         <= run_next;
            fb_rd_en    <= low_start_c;
            fb_addr_top <= addr_top_d;
            fb_addr_bot <= addr_bot_d;
            panel_lat   <= (state_next == LATCH);
            panel_oe_n  <= (state_next != DISPLAY);
            row_addr    <= row_addr_d;
            frame_done  <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Self-checking bench for hub75_scan_ctrl on a 4x4 panel, compared against a
// row-period arithmetic model and a model framebuffer with random contents.
module tb_hub75_scan_ctrl;

    localparam int COLS    = 4;
    localparam int ROWS    = 4;
    localparam int CLK_DIV = 2;
    localparam int OE      = 5;
    localparam int HALF    = ROWS / 2;
    localparam int AW      = 4;
    localparam int RW      = 1;
    localparam int D2      = 2 * CLK_DIV;
    localparam int SH      = COLS * D2;
    localparam int P       = SH + 2 + OE;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] top;
        logic [AW-1:0] bot;
        logic          pclk;
        logic          lat;
        logic          oe_n;
        logic [RW-1:0] ra;
        logic          fd;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          fb_rd_en;
    logic [AW-1:0] fb_addr_top;
    logic [AW-1:0] fb_addr_bot;
    logic          panel_clk;
    logic          panel_lat;
    logic          panel_oe_n;
    logic [RW-1:0] row_addr;
    logic          frame_done;

    logic [2:0]    mem [ROWS*COLS];
    logic [2:0]    rgb_top;
    logic [2:0]    rgb_bot;
    obs_t          obs;

    int n_checks = 0;
    int n_fail   = 0;

    hub75_scan_ctrl #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .CLK_DIV   (CLK_DIV),
        .OE_CYCLES (OE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .fb_rd_en    (fb_rd_en),
        .fb_addr_top (fb_addr_top),
        .fb_addr_bot (fb_addr_bot),
        .panel_clk   (panel_clk),
        .panel_lat   (panel_lat),
        .panel_oe_n  (panel_oe_n),
        .row_addr    (row_addr),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous framebuffer; bit-select is a direct pass-through.
    always_ff @(posedge clk) begin
        if (fb_rd_en) begin
            rgb_top <= mem[fb_addr_top];
            rgb_bot <= mem[fb_addr_bot];
        end
    end

    assign obs = {fb_rd_en, fb_addr_top, fb_addr_bot, panel_clk, panel_lat,
                  panel_oe_n, row_addr, frame_done};

    // Expected outputs t cycles after the first SHIFT cycle, en held high.
    function automatic obs_t model(int t, int sr, int ra0);
        obs_t e;
        int rowidx, row, p, col, ph;
        rowidx = t / P;
        row    = (sr + rowidx) % HALF;
        p      = t % P;
        if (p < SH) begin
            col = p / D2;
            ph  = p % D2;
        end else begin
            col = COLS - 1;
            ph  = 0;
        end
        e.rd   = (p < SH) && (ph == 0);
        e.pclk = (p < SH) && (ph >= CLK_DIV);
        e.top  = AW'(row * COLS + col);
        e.bot  = AW'((row + HALF) * COLS + col);
        e.lat  = (p == SH + 1);
        e.oe_n = (p < SH + 2);
        if (p >= SH)          e.ra = RW'(row);
        else if (rowidx == 0) e.ra = RW'(ra0);
        else                  e.ra = RW'((row + HALF - 1) % HALF);
        e.fd   = (p == P - 1) && (row == HALF - 1);
        return e;
    endfunction

    function automatic obs_t reset_obs();
        obs_t r;
        r = '0;
        r.oe_n = 1'b1;
        return r;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < ROWS * COLS; i++) mem[i] = 3'($urandom);
    endtask

    // Reset, then release with en high; returns on the edge where IDLE samples en.
    task automatic start_run();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        obs_t r;
        r = reset_obs();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== r) begin
                n_fail++;
                $display("FAIL reset_hold i=%0d got=%h exp=%h", i, obs, r);
            end
            en = 1'($urandom);
        end
    endtask

    task automatic test_frames();
        obs_t e;
        int fd_cnt, fd_t0, fd_t1;
        fd_cnt = 0; fd_t0 = -1; fd_t1 = -1;
        fill_mem();
        start_run();
        for (int t = 0; t < 2 * HALF * P; t++) begin
            @(negedge clk);
            e = model(t, 0, 0);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL frame_cycle t=%0d got=%h exp=%h", t, obs, e);
            end
            if (e.pclk && ((t % P) % D2 == CLK_DIV)) begin
                n_checks++;
                if ({rgb_top, rgb_bot} !== {mem[e.top], mem[e.bot]}) begin
                    n_fail++;
                    $display("FAIL rgb_at_rise t=%0d got=%h exp=%h", t,
                             {rgb_top, rgb_bot}, {mem[e.top], mem[e.bot]});
                end
            end
            if (t == P + 2 * D2) begin
                n_checks++;
                if ({fb_addr_top, fb_addr_bot} !== {4'd6, 4'd14}) begin
                    n_fail++;
                    $display("FAIL addr_r1c2 got=%0d/%0d exp=6/14", fb_addr_top, fb_addr_bot);
                end
            end
            if (frame_done) begin
                fd_cnt++;
                if (fd_t0 < 0) fd_t0 = t;
                else           fd_t1 = t;
            end
        end
        n_checks++;
        if (fd_cnt != 2) begin
            n_fail++;
            $display("FAIL frame_done_count got=%0d exp=2", fd_cnt);
        end
        n_checks++;
        if (fd_t1 - fd_t0 != HALF * P) begin
            n_fail++;
            $display("FAIL frame_period got=%0d exp=%0d", fd_t1 - fd_t0, HALF * P);
        end
    endtask

    task automatic test_enable_drop();
        obs_t e;
        int idle_n;
        fill_mem();
        start_run();
        for (int t = 0; t < 2 * P - 1; t++) begin
            @(negedge clk);
            e = model(t, 0, 0);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL drop_cycle t=%0d got=%h exp=%h", t, obs, e);
            end
            if (t == P + 3) en = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if ({panel_oe_n, frame_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL drop_last_lit oe_n/fd got=%b exp=00", {panel_oe_n, frame_done});
        end
        idle_n = int'($urandom_range(3, 8));
        for (int i = 0; i < idle_n; i++) begin
            @(negedge clk);
            n_checks++;
            if ({panel_oe_n, panel_clk, panel_lat, fb_rd_en, row_addr} !== 5'b10001) begin
                n_fail++;
                $display("FAIL drop_idle i=%0d got=%b exp=10001", i,
                         {panel_oe_n, panel_clk, panel_lat, fb_rd_en, row_addr});
            end
        end
        en = 1'b1;
        @(posedge clk);
        for (int t = 0; t < P; t++) begin
            @(negedge clk);
            e = model(t, 1, 1);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL resume_cycle t=%0d got=%h exp=%h", t, obs, e);
            end
            if (t == 0) begin
                n_checks++;
                if ({fb_rd_en, fb_addr_top} !== {1'b1, 4'd4}) begin
                    n_fail++;
                    $display("FAIL resume_addr got=%b/%0d exp=1/4", fb_rd_en, fb_addr_top);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t r;
        int k;
        r = reset_obs();
        fill_mem();
        start_run();
        k = SH + 2 + int'($urandom_range(0, OE - 2));
        for (int t = 0; t <= k; t++) @(negedge clk);
        n_checks++;
        if (panel_oe_n !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_lit got=%b exp=0", panel_oe_n);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== r) begin
            n_fail++;
            $display("FAIL async_reset got=%h exp=%h", obs, r);
        end
        @(negedge clk);
        n_checks++;
        if (obs !== r) begin
            n_fail++;
            $display("FAIL reset_held got=%h exp=%h", obs, r);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({fb_rd_en, fb_addr_top, fb_addr_bot, panel_clk} !== {1'b1, 4'd0, 4'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL post_reset_addr got=%b/%0d/%0d/%b exp=1/0/8/0",
                     fb_rd_en, fb_addr_top, fb_addr_bot, panel_clk);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_enable_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
